present80_key_sched: RTL and testbench
======================================

// Module: present80_key_sched
// PURPOSE
//  PRESENT-80 round-key generator feeding the 64-bit PRESENT cipher core (the plain_text/master_key/start/done block).
//  Latches an 80-bit master key and steps the key register one round per request.
//  Presents the 64-bit round key K_i = key_reg[79:16] together with its round index i (1..32).
//  The core XORs K_i in round i and uses K32 as the final whitening key.
// PARAMETERS
//  KEY_W    80  key register width; fixed for PRESENT-80
//  RK_W     64  round-key width = block width
//  ROUNDS   32  number of round keys K1..K32
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous reset, active-high
//  master_key  in   80  user key; sampled only on an accepted key_load
//  key_load    in   1   1-cycle pulse: load master_key, start a new schedule
//  rk_next     in   1   advance K_i -> K_(i+1)
//  round_key   out  64  current round key K_i = key_reg[79:16]
//  rk_round    out  5   index i of round_key; 1..32 encoded as i-1 (0..31)
//  rk_valid    out  1   round_key/rk_round are valid
//  rk_last     out  1   rk_valid && i==32
//  busy        out  1   precompute in progress (macro build only; tied 0 otherwise)
// BEHAVIOUR
//  Reset (async, any state): key_reg=0, rk_round=0, rk_valid=0, rk_last=0, busy=0, state=IDLE.
//  FSM: IDLE -> READY on key_load; READY -> READY on key_load (reload).
//  Load: the edge after key_load gives key_reg=master_key, i=1, rk_valid=1 (1-cycle latency).
//  Forward step, counter c=i (5-bit), on rk_next in READY with i<32:
//   1) key_reg = {key_reg[18:0], key_reg[79:19]}  (rotate left 61)
//   2) key_reg[79:76] = SBOX[key_reg[79:76]]
//   3) key_reg[19:15] ^= c;  then i <= i+1
//   New K_(i+1) is valid on the edge after rk_next: one step per cycle, back-to-back allowed.
//  Boundaries:
//   - rk_next at i==32: ignored; key, index and rk_last=1 hold.
//   - rk_next in IDLE: ignored.
//   - key_load and rk_next in the same cycle: key_load wins.
//   - key_load mid-schedule: discards the current schedule, restarts at i=1 with the new key.
//   - rk_valid stays 1 from first load until reset.
//  SBOX = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (index 0..F).
// CONFIGURATION
//  Macro PRESENT_INV_SCHED_EN enables decryption ordering.
//  With the macro:
//   - Extra inputs rk_prev (1) and key_load_inv (1).
//   - key_load_inv: loads master_key, enters state PRECOMP with busy=1, rk_valid=0.
//     Steps forward once per cycle for 31 cycles, then enters READY at i=32, busy=0, rk_valid=1.
//   - rk_prev in READY with i>1, counter c=i-1:
//     key_reg[19:15]^=c; top nibble = INV_SBOX; rotate right 61; i <= i-1.
//   - rk_prev at i==1: ignored.  rk_next together with rk_prev: both ignored.
//   - rk_next/rk_prev during PRECOMP: ignored.
//   - key_load or key_load_inv during PRECOMP: restarts; key_load_inv wins over key_load.
//  Without the macro: no PRECOMP state, no rk_prev/key_load_inv ports, busy tied 0.
// STRUCTURE
//  Package present_pkg: KEY_W, RK_W, ROUNDS, SBOX[16] and INV_SBOX[16] constants,
//   function sbox4/inv_sbox4, state enum {IDLE, READY, PRECOMP}.
//  Sub-module present80_key_step: combinational single-round update.
//   Inputs key_in[79:0], cnt[4:0], dir (0=fwd, 1=inv); output key_out[79:0].
//   Shared by the forward and inverse paths; the top level holds key_reg, the counter and the FSM.
// TESTING
//  1) rst=1 for 2 cycles, then release -> rk_valid=0, round_key=0, rk_round=0, busy=0.
//  2) Zero key, key_load, then rk_next x2:
//     K1=0000000000000000, K2=C000000000000000, K3=5000180000000001; rk_round = 0,1,2.
//  3) Zero key, 31 back-to-back rk_next -> rk_last=1 at rk_round=31.
//     A further rk_next changes nothing; round_key matches the golden model K32.
//  4) key_load together with rk_next at i=10, using a new key -> next cycle i=1, round_key = new_key[79:16].
//  5) Async rst asserted mid-schedule (between clock edges) -> all outputs 0 immediately, FSM in IDLE.
//  6) [PRESENT_INV_SCHED_EN] Random key, key_load_inv:
//     busy=1 for 31 cycles, then round_key=K32; 31 rk_prev steps reproduce K31..K1 = forward run.
//     A rk_prev at i==1 is ignored.

Source files
------------

// File: rtl/present_pkg.sv
// PRESENT-80 key-schedule shared definitions: widths, S-box tables, state type.
// Used by present80_key_step and present80_key_sched.
package present_pkg;

  localparam int KEY_W  = 80;
  localparam int RK_W   = 64;
  localparam int ROUNDS = 32;
  localparam int RND_W  = $clog2(ROUNDS);

  // Round index is stored as i-1, so the last round key K32 sits at 31.
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    return INV_SBOX[x];
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    PRECOMP = 2'd2
  } state_e;

endpackage

// File: rtl/present80_key_step.sv
// One PRESENT-80 key-schedule round, purely combinational.
// dir=0: rotate left 61, S-box top nibble, xor counter into bits 19:15.
// dir=1: exact inverse of the above (xor counter, inverse S-box, rotate right 61).
module present80_key_step
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] key_in,
  input  logic [4:0]       cnt,
  input  logic             dir,
  output logic [KEY_W-1:0] key_out
);

  logic [KEY_W-1:0] fwd_rot;
  logic [KEY_W-1:0] fwd_key;
  logic [KEY_W-1:0] inv_xor;
  logic [KEY_W-1:0] inv_sub;
  logic [KEY_W-1:0] inv_key;

  // Build both directions and select; the top level decides which one is used.
  // NOTE: every variable gets a full default assignment before any partial
  // update, so no path leaves a bit unassigned and no latch is inferred.
  always_comb begin
    fwd_rot          = {key_in[18:0], key_in[79:19]};
    fwd_key          = fwd_rot;
    fwd_key[79:76]   = sbox4(fwd_rot[79:76]);
    fwd_key[19:15]   = fwd_rot[19:15] ^ cnt;

    inv_xor          = key_in;
    inv_xor[19:15]   = key_in[19:15] ^ cnt;
    inv_sub          = inv_xor;
    inv_sub[79:76]   = inv_sbox4(inv_xor[79:76]);
    inv_key          = {inv_sub[60:0], inv_sub[79:61]};

    key_out          = dir ? inv_key : fwd_key;
  end

endmodule

// File: rtl/present80_key_sched.sv
// PRESENT-80 round-key generator: holds the 80-bit key register, the round
// index and the load/step FSM; presents K_i = key_reg[79:16] with index i-1.
// Optional macro PRESENT_INV_SCHED_EN adds decryption ordering: key_load_inv
// precomputes K32 over 31 cycles (busy=1), then rk_prev walks back to K1.
module present80_key_sched
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] master_key,
  input  logic             key_load,
  input  logic             rk_next,
`ifdef PRESENT_INV_SCHED_EN
  input  logic             rk_prev,
  input  logic             key_load_inv,
`endif
  output logic [RK_W-1:0]  round_key,
  output logic [RND_W-1:0] rk_round,
  output logic             rk_valid,
  output logic             rk_last,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [KEY_W-1:0] step_key;
  logic [RND_W-1:0] step_cnt;
  logic             step_dir;
  logic             fwd_ok;
  logic             inv_ok;

  // A forward step needs READY and i<32; with the inverse build, a
  // simultaneous rk_prev cancels it.
`ifdef PRESENT_INV_SCHED_EN
  assign fwd_ok = (state_q == READY) && rk_next && !rk_prev && (rnd_q != LAST_RND);
  assign inv_ok = (state_q == READY) && rk_prev && !rk_next && (rnd_q != '0);
`else
  assign fwd_ok = (state_q == READY) && rk_next && (rnd_q != LAST_RND);
  assign inv_ok = 1'b0;
`endif

  // Forward uses c=i (stored i-1 plus one); inverse uses c=i-1 (stored value).
  assign step_dir = inv_ok;
  assign step_cnt = inv_ok ? rnd_q : rnd_q + 1'b1;

  present80_key_step u_step (
    .key_in  (key_q),
    .cnt     (step_cnt),
    .dir     (step_dir),
    .key_out (step_key)
  );

  // Next-state: loads take priority over stepping; illegal steps hold state.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
`ifdef PRESENT_INV_SCHED_EN
    if (key_load_inv) begin
      state_d = PRECOMP;
      key_d   = master_key;
      rnd_d   = '0;
    end else
`endif
    if (key_load) begin
      state_d = READY;
      key_d   = master_key;
      rnd_d   = '0;
    end else begin
      case (state_q)
        READY: begin
          if (fwd_ok) begin
            key_d = step_key;
            rnd_d = rnd_q + 1'b1;
          end else if (inv_ok) begin
            key_d = step_key;
            rnd_d = rnd_q - 1'b1;
          end
        end
`ifdef PRESENT_INV_SCHED_EN
        PRECOMP: begin
          key_d = step_key;
          rnd_d = rnd_q + 1'b1;
          if (rnd_q == LAST_RND - 1'b1) begin
            state_d = READY;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // State, key register and round index; all clear on asynchronous reset.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  assign round_key = key_q[KEY_W-1 -: RK_W];
  assign rk_round  = rnd_q;
  assign rk_valid  = (state_q == READY);
  assign rk_last   = rk_valid && (rnd_q == LAST_RND);
`ifdef PRESENT_INV_SCHED_EN
  assign busy      = (state_q == PRECOMP);
`else
  assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_present80_key_sched.sv
// Self-checking bench for present80_key_sched. A driver issues one input
// vector per cycle and pushes the reference model's expected outputs into a
// queue; a monitor pops and compares one entry after each rising edge.
// The inverse-schedule section is active when PRESENT_INV_SCHED_EN is defined.
module tb_present80_key_sched;

  typedef struct packed {
    logic [63:0] key;
    logic [4:0]  rnd;
    logic        valid;
    logic        last;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] master_key;
  logic        key_load;
  logic        rk_next;
`ifdef PRESENT_INV_SCHED_EN
  logic        rk_prev;
  logic        key_load_inv;
`endif
  logic [63:0] round_key;
  logic [4:0]  rk_round;
  logic        rk_valid;
  logic        rk_last;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];

  // Reference model state: the whole schedule K1..K32 is computed from the
  // master key up front; the model then only tracks which index is shown.
  logic [63:0] m_sched [1:32];
  logic [3:0]  sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  bit m_loaded, m_valid, m_pre;
  int m_i, m_pre_left;

  always #5 clk = ~clk;

  present80_key_sched dut (
    .clk          (clk),
    .rst          (rst),
    .master_key   (master_key),
    .key_load     (key_load),
    .rk_next      (rk_next),
`ifdef PRESENT_INV_SCHED_EN
    .rk_prev      (rk_prev),
    .key_load_inv (key_load_inv),
`endif
    .round_key    (round_key),
    .rk_round     (rk_round),
    .rk_valid     (rk_valid),
    .rk_last      (rk_last),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic gen_sched(input logic [79:0] mk);
    logic [79:0] k;
    logic [3:0]  top;
    k = mk;
    m_sched[1] = 64'(k >> 16);
    for (int c = 1; c < 32; c++) begin
      k = (k << 61) | (k >> 19);
      top = 4'(k >> 76);
      k = (k & ~(80'hF << 76)) | (80'(sb[top]) << 76);
      k = k ^ (80'(c) << 15);
      m_sched[c + 1] = 64'(k >> 16);
    end
  endtask

  task automatic model_reset();
    m_loaded = 0; m_valid = 0; m_pre = 0; m_i = 1; m_pre_left = 0;
  endtask

  task automatic model_step(input bit ld, input bit ldi, input bit nx, input bit pv,
                            input logic [79:0] key);
    if (ldi) begin
      gen_sched(key); m_loaded = 1; m_i = 1; m_pre = 1; m_pre_left = 31; m_valid = 0;
    end else if (ld) begin
      gen_sched(key); m_loaded = 1; m_i = 1; m_pre = 0; m_valid = 1;
    end else if (m_pre) begin
      m_i++; m_pre_left--;
      if (m_pre_left == 0) begin m_pre = 0; m_valid = 1; end
    end else if (m_valid) begin
      if (nx && !pv && m_i < 32) m_i++;
      else if (pv && !nx && m_i > 1) m_i--;
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expectation
  // for the following rising edge.
  task automatic cycle(input bit ld, input bit nx, input bit pv, input bit ldi,
                       input logic [79:0] key);
    exp_t e;
    @(negedge clk);
    master_key = key;
    key_load   = ld;
    rk_next    = nx;
`ifdef PRESENT_INV_SCHED_EN
    rk_prev      = pv;
    key_load_inv = ldi;
`else
    pv  = 1'b0;
    ldi = 1'b0;
`endif
    model_step(ld, ldi, nx, pv, key);
    e.key   = m_loaded ? m_sched[m_i] : 64'h0;
    e.rnd   = m_loaded ? 5'(m_i - 1) : 5'd0;
    e.valid = m_valid;
    e.last  = m_valid && (m_i == 32);
    e.busy  = m_pre;
    exp_q.push_back(e);
  endtask

  function automatic logic [79:0] rand_key();
    return {16'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  // Monitor: one queued expectation per rising edge, compared 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_round_key", 80'(round_key), 80'(e.key));
        check("sb_flags", 80'({rk_round, rk_valid, rk_last, busy}),
              80'({e.rnd, e.valid, e.last, e.busy}));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] k_a, k_b;
    rst = 1'b1; master_key = '0; key_load = 0; rk_next = 0;
`ifdef PRESENT_INV_SCHED_EN
    rk_prev = 0; key_load_inv = 0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    // 1) Reset state.
    check("rst_valid", 80'(rk_valid), 80'(0));
    check("rst_round_key", 80'(round_key), 80'(0));
    check("rst_round", 80'(rk_round), 80'(0));
    check("rst_busy", 80'(busy), 80'(0));

    // rk_next while IDLE is ignored.
    cycle(0, 1, 0, 0, 80'h0);

    // 2) Zero key: golden K1..K3.
    cycle(1, 0, 0, 0, 80'h0);
    @(posedge clk); #2;
    check("k1", 80'(round_key), 80'(64'h0000000000000000));
    check("k1_round", 80'(rk_round), 80'(0));
    cycle(0, 1, 0, 0, 80'h0);
    @(posedge clk); #2;
    check("k2", 80'(round_key), 80'(64'hC000000000000000));
    check("k2_round", 80'(rk_round), 80'(1));
    cycle(0, 1, 0, 0, 80'h0);
    @(posedge clk); #2;
    check("k3", 80'(round_key), 80'(64'h5000180000000001));
    check("k3_round", 80'(rk_round), 80'(2));

    // 3) Full forward run, then a step beyond K32 is ignored.
    cycle(1, 0, 0, 0, 80'h0);
    for (int j = 0; j < 31; j++) cycle(0, 1, 0, 0, 80'h0);
    @(posedge clk); #2;
    check("k32_last", 80'(rk_last), 80'(1));
    check("k32_round", 80'(rk_round), 80'(31));
    cycle(0, 1, 0, 0, 80'h0);
    @(posedge clk); #2;
    check("k32_hold_key", 80'(round_key), 80'(m_sched[32]));
    check("k32_hold_round", 80'(rk_round), 80'(31));

    // 4) key_load beats rk_next at i=10.
    k_a = rand_key();
    k_b = rand_key();
    cycle(1, 0, 0, 0, k_a);
    for (int j = 0; j < 9; j++) cycle(0, 1, 0, 0, k_a);
    cycle(1, 1, 0, 0, k_b);
    @(posedge clk); #2;
    check("reload_key", 80'(round_key), 80'(k_b[79:16]));
    check("reload_round", 80'(rk_round), 80'(0));

    // 5) Asynchronous reset between edges.
    for (int j = 0; j < 4; j++) cycle(0, 1, 0, 0, k_b);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_round_key", 80'(round_key), 80'(0));
    check("arst_round", 80'(rk_round), 80'(0));
    check("arst_valid", 80'(rk_valid), 80'(0));
    check("arst_last", 80'(rk_last), 80'(0));
    check("arst_busy", 80'(busy), 80'(0));
    model_reset();
    @(negedge clk);
    key_load = 0; rk_next = 0;
`ifdef PRESENT_INV_SCHED_EN
    rk_prev = 0; key_load_inv = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 1, 0, 0, k_b);

`ifdef PRESENT_INV_SCHED_EN
    // 6) Inverse schedule: precompute K32, then walk back to K1.
    k_a = rand_key();
    cycle(0, 0, 0, 1, k_a);
    @(posedge clk); #2;
    check("pre_busy", 80'(busy), 80'(1));
    for (int j = 0; j < 31; j++) cycle(0, $urandom_range(0, 1), $urandom_range(0, 1), 0, k_a);
    @(posedge clk); #2;
    check("pre_done_busy", 80'(busy), 80'(0));
    check("pre_done_key", 80'(round_key), 80'(m_sched[32]));
    cycle(0, 1, 1, 0, k_a);
    for (int j = 0; j < 31; j++) cycle(0, 0, 1, 0, k_a);
    cycle(0, 0, 1, 0, k_a);
    @(posedge clk); #2;
    check("inv_k1_key", 80'(round_key), 80'(k_a[79:16]));
    check("inv_k1_round", 80'(rk_round), 80'(0));
`endif

    // Randomized mix of loads and steps.
    k_a = rand_key();
    cycle(1, 0, 0, 0, k_a);
    for (int j = 0; j < 400; j++) begin
      cycle(($urandom % 25) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
            ($urandom % 60) == 0, rand_key());
    end

    @(posedge clk); #2;
    check("queue_drained", 80'(exp_q.size()), 80'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
